// File: rtl/mux_sel_scan_capture_if.sv
// Downstream word handshake for the mux scan-capture stage.
//   word        captured N-bit sample vector
//   word_valid  word complete and stable
//   word_ready  downstream accepts word
// master: the capture stage (drives word/word_valid), slave: the consumer.
interface mux_sel_scan_capture_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] word;
    logic         word_valid;
    logic         word_ready;

    modport master (output word, output word_valid, input word_ready);
    modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/mux_sel_scan_capture.sv
// Scan stage wrapped around an 8:1 mux under test. Steps the select through every code,
// holds each code for SETTLE+1 cycles, samples mux_out on the last cycle of each hold into
// word[sel], then offers the finished word downstream with a valid/ready handshake.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request a scan (only honoured when idle)
//   abort       synchronous abort, highest priority after reset
//   sel         registered mux select
//   mux_out     mux output, combinational from sel
//   out_if      word / word_valid / word_ready handshake (master side)
//   busy        high while scanning or holding a finished word
module mux_sel_scan_capture #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic [SEL_W-1:0]        sel,
    input  logic                    mux_out,
    mux_sel_scan_capture_if.master  out_if,
    output logic                    busy
);
    localparam int unsigned N     = 2 ** SEL_W;
    localparam int unsigned CNT_W = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     word_q, word_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;

        if (abort) begin
            // word is deliberately kept so a partial capture stays observable
            state_d = StIdle;
            sel_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StScan;
                        sel_d   = '0;
                        cnt_d   = '0;
                        word_d  = '0;
                    end
                end
                StScan: begin
                    // cnt only counts up from 0, so != is the same as < here
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        word_d[sel_q] = mux_out;
                        if (sel_q != SEL_LAST) begin
                            sel_d = sel_q + 1'b1;
                            cnt_d = '0;
                        end else begin
                            state_d = StDone;
                            valid_d = 1'b1;
                        end
                    end
                end
                StDone: begin
                    // start is not looked at here, so a new scan needs a fresh idle cycle
                    if (valid_q && out_if.word_ready) begin
                        state_d = StIdle;
                        sel_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    sel_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sel               = sel_q;
    assign busy              = busy_q;
    assign out_if.word       = word_q;
    assign out_if.word_valid = valid_q;
endmodule
